// File: rtl/core_defs.sv
// Shared definitions for the 16-bit five-phase core.
// Phases, instruction classes, ALU ops, branch conditions, flag bits.
package core_defs;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 3;

  localparam logic [2:0] PHASE_IDLE   = 3'd0;
  localparam logic [2:0] PHASE_FETCH  = 3'd1;
  localparam logic [2:0] PHASE_DECODE = 3'd2;
  localparam logic [2:0] PHASE_EXEC   = 3'd3;
  localparam logic [2:0] PHASE_MEM    = 3'd4;
  localparam logic [2:0] PHASE_WB     = 3'd5;

  typedef enum logic [1:0] {
    CLS_LD   = 2'b00,
    CLS_ST   = 2'b01,
    CLS_MISC = 2'b10,
    CLS_ALU  = 2'b11
  } cls_e;

  localparam logic [2:0] SUB_LI  = 3'b000;
  localparam logic [2:0] SUB_B   = 3'b100;
  localparam logic [2:0] SUB_BCC = 3'b111;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_NEG = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SLR = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1100;
  localparam logic [3:0] OP_OUT = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;

  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic op_writes(logic [3:0] op);
    return (op <= OP_XOR) || (op == OP_NEG) ||
           (op >= OP_SLL && op <= OP_SRA) || (op == OP_MOV);
  endfunction

  function automatic logic op_sets_flags(logic [3:0] op);
    return (op <= OP_NEG) || (op >= OP_SLL && op <= OP_SRA);
  endfunction

  function automatic logic cond_true(logic [2:0] c, logic [3:0] f);
    logic lt;
    lt = f[FLAG_S] ^ f[FLAG_V];
    unique case (c)
      COND_BE:  return f[FLAG_Z];
      COND_BLT: return lt;
      COND_BLE: return f[FLAG_Z] | lt;
      COND_BNE: return ~f[FLAG_Z];
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two async read ports, one sync write port.
// Synchronous active-high reset clears every register.
module reg_file_8x16
  import core_defs::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

  // Reset wins over a same-cycle write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: instruction decode, operand fetch, flags,
// branch resolution, writeback and sticky halt.
module decode_regfile
  import core_defs::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  phase_counter,
  input  logic [15:0] instruction_register,
  input  logic [3:0]  alu_flags,
  input  logic [15:0] writeback_data,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [15:0] immediate,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        op_branch,
  output logic        halt
);

  logic [15:0] r_opa;
  logic [15:0] r_opb;
  logic [15:0] r_imm;
  logic [3:0]  r_alu_op;
  logic [3:0]  r_flags;
  logic        r_branch;
  logic        r_halt;

  cls_e        w_cls;
  logic [2:0]  w_sub;
  logic [3:0]  w_op3;
  logic [2:0]  w_cond;
  logic        w_is_ld;
  logic        w_is_li;
  logic        w_is_b;
  logic        w_is_bcc;
  logic        w_is_alu;
  logic        w_writes;
  logic        w_set_flags;
  logic        w_is_hlt;
  logic [15:0] w_imm;
  logic [2:0]  w_waddr;
  logic [15:0] w_rdata_a;
  logic [15:0] w_rdata_b;

  assign w_cls  = cls_e'(instruction_register[15:14]);
  assign w_sub  = instruction_register[13:11];
  assign w_cond = instruction_register[10:8];
  assign w_op3  = instruction_register[7:4];

  // Class and sub-op decode.
  always_comb begin
    w_is_ld  = 1'b0;
    w_is_li  = 1'b0;
    w_is_b   = 1'b0;
    w_is_bcc = 1'b0;
    w_is_alu = 1'b0;
    unique case (1'b1)
      (w_cls == CLS_LD):   w_is_ld  = 1'b1;
      (w_cls == CLS_ALU):  w_is_alu = 1'b1;
      (w_cls == CLS_MISC): begin
        w_is_li  = (w_sub == SUB_LI);
        w_is_b   = (w_sub == SUB_B);
        w_is_bcc = (w_sub == SUB_BCC);
      end
      default: ;
    endcase
  end

  assign w_writes    = w_is_ld | w_is_li | (w_is_alu & op_writes(w_op3));
  assign w_set_flags = w_is_alu & op_sets_flags(w_op3);
  assign w_is_hlt    = w_is_alu & (w_op3 == OP_HLT);
  assign w_waddr     = w_is_ld ? instruction_register[13:11]
                               : instruction_register[10:8];
  assign w_imm       = w_is_alu
                     ? {12'h000, instruction_register[3:0]}
                     : {{8{instruction_register[7]}},
                        instruction_register[7:0]};

  assign reg_write = w_writes & (phase_counter == PHASE_WB) & ~r_halt;

  reg_file_8x16 u_rf (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_raddr_a (instruction_register[13:11]),
    .i_raddr_b (instruction_register[10:8]),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .i_we      (reg_write),
    .i_waddr   (w_waddr),
    .i_wdata   (writeback_data)
  );

  // Per-phase latching; a halted stage freezes until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_opa    <= '0;
      r_opb    <= '0;
      r_imm    <= '0;
      r_alu_op <= '0;
      r_flags  <= '0;
      r_branch <= 1'b0;
      r_halt   <= 1'b0;
    end else if (!r_halt) begin
      unique case (phase_counter)
        PHASE_DECODE: begin
          r_opa    <= w_rdata_a;
          r_opb    <= w_rdata_b;
          r_imm    <= w_imm;
          r_alu_op <= w_is_alu ? w_op3 : OP_ADD;
          if (w_is_hlt)
            r_halt <= 1'b1;
        end
        PHASE_EXEC: begin
          if (w_set_flags)
            r_flags <= alu_flags;
        end
        PHASE_MEM: begin
          r_branch <= w_is_b |
                      (w_is_bcc & cond_true(w_cond, r_flags));
        end
        PHASE_WB: ;
        default: r_branch <= 1'b0;
      endcase
    end
  end

  assign operand_a = r_opa;
  assign operand_b = r_opb;
  assign immediate = r_imm;
  assign alu_op    = r_alu_op;
  assign op_branch = r_branch;
  assign halt      = r_halt;

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile with a scoreboard queue.
// Each instruction is stepped through phases 1..5.
module tb_decode_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  phase_counter;
  logic [15:0] instruction_register;
  logic [3:0]  alu_flags;
  logic [15:0] writeback_data;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [15:0] immediate;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic        op_branch;
  logic        halt;

  decode_regfile dut (
    .clock                (clock),
    .reset                (reset),
    .phase_counter        (phase_counter),
    .instruction_register (instruction_register),
    .alu_flags            (alu_flags),
    .writeback_data       (writeback_data),
    .operand_a            (operand_a),
    .operand_b            (operand_b),
    .immediate            (immediate),
    .alu_op               (alu_op),
    .reg_write            (reg_write),
    .op_branch            (op_branch),
    .halt                 (halt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic [15:0] s_imm, s_opa, s_opb;
  logic [3:0]  s_aluop;
  logic        s_halt, s_br, s_rw;

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: got %h, no expected value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic step(input logic [2:0] p);
    @(negedge clock);
    phase_counter = p;
    #1;
  endtask

  task automatic instr(input logic [15:0] ir,
                       input logic [3:0]  fl,
                       input logic [15:0] wb);
    instruction_register = ir;
    alu_flags            = 4'h0;
    writeback_data       = wb;
    step(3'd1);
    step(3'd2);
    alu_flags = fl;
    step(3'd3);
    s_imm   = immediate;
    s_opa   = operand_a;
    s_opb   = operand_b;
    s_aluop = alu_op;
    s_halt  = halt;
    step(3'd4);
    step(3'd5);
    s_br = op_branch;
    s_rw = reg_write;
    step(3'd0);
  endtask

  initial begin
    reset                = 1'b1;
    phase_counter        = 3'd0;
    instruction_register = 16'h0000;
    alu_flags            = 4'h0;
    writeback_data       = 16'h0000;
    repeat (3) @(negedge clock);

    push("rst_opa", 16'h0000);   check(operand_a);
    push("rst_opb", 16'h0000);   check(operand_b);
    push("rst_imm", 16'h0000);   check(immediate);
    push("rst_aluop", 16'h0000); check({12'h0, alu_op});
    push("rst_br", 16'h0000);    check({15'h0, op_branch});
    push("rst_halt", 16'h0000);  check({15'h0, halt});
    reset = 1'b0;

    // Reset landing on the phase-5 edge discards the write.
    instruction_register = 16'h83FE;
    step(3'd1); step(3'd2); step(3'd3); step(3'd4);
    @(negedge clock);
    phase_counter  = 3'd5;
    writeback_data = 16'h1234;
    reset          = 1'b1;
    @(negedge clock);
    reset         = 1'b0;
    phase_counter = 3'd0;
    #1;
    for (int i = 0; i < 8; i++) begin
      push($sformatf("rst5_r%0d", i), 16'h0000);
      check(dut.u_rf.r_regs[i]);
    end
    push("rst5_br", 16'h0000);   check({15'h0, op_branch});
    push("rst5_halt", 16'h0000); check({15'h0, halt});

    // LI r3,#-2
    push("li_imm", 16'hFFFE);
    push("li_rw", 16'h0001);
    push("li_r3", 16'hFFFE);
    instr(16'h83FE, 4'h0, 16'hFFFE);
    check(s_imm);
    check({15'h0, s_rw});
    check(dut.u_rf.r_regs[3]);

    // ADD r3,r3
    push("add_opa", 16'hFFFE);
    push("add_opb", 16'hFFFE);
    push("add_aluop", 16'h0000);
    push("add_halt", 16'h0000);
    push("add_r3", 16'hFFFC);
    instr(16'hDB00, 4'h0, 16'hFFFC);
    check(s_opa);
    check(s_opb);
    check({12'h0, s_aluop});
    check({15'h0, s_halt});
    check(dut.u_rf.r_regs[3]);

    // SUB r0,r3
    push("sub_aluop", 16'h0001);
    push("sub_opa", 16'h0000);
    push("sub_opb", 16'hFFFC);
    push("sub_r3", 16'h0002);
    instr(16'hC310, 4'h0, 16'h0002);
    check({12'h0, s_aluop});
    check(s_opa);
    check(s_opb);
    check(dut.u_rf.r_regs[3]);

    // LD r5,3(r0): writes the Ra field
    push("ld_imm", 16'h0003);
    push("ld_rw", 16'h0001);
    push("ld_r5", 16'h5555);
    push("ld_r0", 16'h0000);
    instr(16'h2803, 4'h0, 16'h5555);
    check(s_imm);
    check({15'h0, s_rw});
    check(dut.u_rf.r_regs[5]);
    check(dut.u_rf.r_regs[0]);

    // CMP sets Z, then BE / BNE
    push("cmp_rw", 16'h0000);
    instr(16'hC050, 4'b0100, 16'h7777);
    check({15'h0, s_rw});
    push("be_imm", 16'h0005);
    push("be_br", 16'h0001);
    push("be_rw", 16'h0000);
    instr(16'hB805, 4'h0, 16'h0000);
    check(s_imm);
    check({15'h0, s_br});
    check({15'h0, s_rw});
    push("br_clr_p1", 16'h0000);
    step(3'd1);
    step(3'd0);
    check({15'h0, op_branch});
    push("bne_br", 16'h0000);
    instr(16'hBB05, 4'h0, 16'h0000);
    check({15'h0, s_br});

    // ST r1,4(r2): no write, flags untouched
    push("st_imm", 16'h0004);
    push("st_rw", 16'h0000);
    push("st_r1", 16'h0000);
    instr(16'h5104, 4'b1000, 16'h9999);
    check(s_imm);
    check({15'h0, s_rw});
    check(dut.u_rf.r_regs[1]);
    push("be_after_st", 16'h0001);
    instr(16'hB805, 4'h0, 16'h0000);
    check({15'h0, s_br});

    // Unconditional B
    push("b_br", 16'h0001);
    push("b_imm", 16'hFFF0);
    instr(16'hA0F0, 4'h0, 16'h0000);
    check({15'h0, s_br});
    check(s_imm);

    // BLT / BLE / reserved cond
    instr(16'hC050, 4'b1000, 16'h0000);
    push("blt_s1v0", 16'h0001);
    instr(16'hB905, 4'h0, 16'h0000);
    check({15'h0, s_br});
    instr(16'hC050, 4'b1001, 16'h0000);
    push("blt_s1v1", 16'h0000);
    instr(16'hB905, 4'h0, 16'h0000);
    check({15'h0, s_br});
    instr(16'hC050, 4'b1100, 16'h0000);
    push("cond100", 16'h0000);
    instr(16'hBC05, 4'h0, 16'h0000);
    check({15'h0, s_br});
    push("ble_z", 16'h0001);
    instr(16'hBA05, 4'h0, 16'h0000);
    check({15'h0, s_br});

    // HLT freezes the stage
    push("hlt_halt", 16'h0001);
    push("hlt_rw", 16'h0000);
    push("hlt_r0", 16'h0000);
    instr(16'hC0F0, 4'h0, 16'hABCD);
    check({15'h0, s_halt});
    check({15'h0, s_rw});
    check(dut.u_rf.r_regs[0]);
    push("halted_rw", 16'h0000);
    push("halted_imm", 16'h0000);
    push("halted_r3", 16'h0002);
    push("halted_halt", 16'h0001);
    instr(16'h8301, 4'h0, 16'h0001);
    check({15'h0, s_rw});
    check(s_imm);
    check(dut.u_rf.r_regs[3]);
    check({15'h0, halt});

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    push("rst_clr_halt", 16'h0000);
    push("rst_clr_r3", 16'h0000);
    check({15'h0, halt});
    check(dut.u_rf.r_regs[3]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Stage directly downstream of fetch in the 5-phase 16-bit core.
- Phase 2: decodes instruction_register, reads the 8x16 register file and latches operands and immediate.
- Phase 3: latches ALU flags. Phase 5: writes back the result and drives op_branch to fetch.
- Raises a sticky halt on HLT.

Parameters:
- NUM_REGS, 8, register count; register index width is 3 bits.
- DATA_W, 16, datapath width.

Ports:
- clock  in  1  system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- phase_counter  in  3  1..5 active phases; 0, 6 and 7 are idle.
- instruction_register  in  16  from fetch; stable during phases 2..5.
- alu_flags  in  4  {S,Z,C,V} from the ALU, valid in phase 3.
- writeback_data  in  16  result to write, valid in phase 5.
- operand_a  out  16  latched Rs/Ra value.
- operand_b  out  16  latched Rd/Rb value.
- immediate  out  16  latched immediate, sign- or zero-extended.
- alu_op  out  4  latched op3 field, or ADD for LD/ST/B address calculation.
- reg_write  out  1  combinational: instruction writes a register and phase_counter==5.
- op_branch  out  1  registered; branch taken, valid in phase 5.
- halt  out  1  sticky HLT indicator.

Behaviour:
- Reset: registers r0..r7=0, operand_a/b=0, immediate=0, alu_op=0, flags=0, op_branch=0, halt=0.
- Reset during any phase discards the in-flight instruction, including any phase-5 write in the same cycle.
- Instruction classes by IR[15:14]:
  - 00 LD, 01 ST: ra=IR[13:11], rb=IR[10:8], d=IR[7:0] sign-extended.
  - 11 arithmetic: rs=IR[13:11], rd=IR[10:8], op3=IR[7:4], d=IR[3:0] zero-extended.
  - 10 with IR[13:11]=000: LI rb=IR[10:8], d8 sign-extended.
  - 10 with IR[13:11]=100: B, unconditional, d8 sign-extended.
  - 10 with IR[13:11]=111: conditional branch, cond=IR[10:8]: 000 BE (Z), 001 BLT (S xor V), 010 BLE (Z or (S xor V)), 011 BNE (not Z). Other cond values are never taken.
- Phase 2 (one edge):
  - operand_a<=reg[IR[13:11]], operand_b<=reg[IR[10:8]].
  - immediate<=extended d; alu_op<=op3 for class 11, else 0000.
  - If class 11 and op3=1111: halt<=1.
- Phase 3: flags<=alu_flags only for class 11 with op3 in {0000..0110, 1000..1011}. All other instructions leave flags unchanged.
- Phase 4: op_branch<=1 if B, or conditional branch with condition true on the current flags; else op_branch<=0.
- Phase 5:
  - Write when reg_write=1: reg[IR[10:8]]<=writeback_data.
  - Writing instructions: class 11 with op3 in {0000..0100, 0110, 1000..1011, 1100}, plus LD and LI. LD writes reg[IR[13:11]].
  - CMP, OUT, HLT, ST and branches never write.
- Phase 1 and idle phases: op_branch<=0. All other state holds.
- No read/write bypass; reads (phase 2) and writes (phase 5) never coincide.
- Halt: once set, the block ignores phase activity and holds all state until reset. Halt is visible from the edge after phase 2.
- Unknown op3 codes (0111, 1110): decode as no-write, no-flag no-ops.

Decomposition:
- Shared package core_defs: PHASE_FETCH..PHASE_WB constants (3'd1..3'd5), class codes, op3 constants (OP_ADD..OP_HLT), branch cond codes, flag bit indices.
- Sub-module reg_file_8x16: two async read ports, one sync write port, sync active-high reset.
- Decode and branch logic stay in decode_regfile.

Test Plan:
- Reset mid-phase-5 with reset=1 and writeback_data=16'h1234: r0..r7 stay 0; op_branch=0; halt=0.
- LI r3,#-2 (IR=16'h83FE), wb=16'hFFFE in phase 5: immediate=16'hFFFE after phase 2; reg_write=1 in phase 5. Then ADD r3,r3 (IR=16'hDB00): operand_a=operand_b=16'hFFFE.
- CMP with alu_flags=4'b0100 (Z) in phase 3, then BE (IR=16'hB805): op_branch=1 in phase 5, immediate=16'h0005. Repeat with BNE (IR=16'hBB05): op_branch=0.
- ST r1,4(r2) (IR=16'h5104): reg_write=0 in phase 5; flags unchanged across the instruction; immediate=16'h0004.
- HLT (IR=16'hC0F0): halt=1 from the edge after phase 2; later phases produce no writes; reset clears halt.
- BLT with flags S=1,V=0 -> op_branch=1; with S=1,V=1 -> op_branch=0; cond=100 -> op_branch=0.
